// File: rtl/hazard_scoreboard.sv
// Hazard detection and pipeline control for the five-stage MIPS pipeline, built on a per-register countdown scoreboard.
// Define HAZARD_PERF_EN to build the 32-bit stall/flush performance counters; otherwise both outputs are tied to 0.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int WB_LATENCY   = 3,
    parameter int FORWARD_EN   = 1,
    parameter int CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  flush_exmem,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int MAX_LAT  = (LOAD_LATENCY > WB_LATENCY) ? LOAD_LATENCY : WB_LATENCY;
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'((FORWARD_EN != 0) ? LOAD_LATENCY : MAX_LAT);
    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(WB_LATENCY);

    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] cntNext [NUM_REGS];
    logic             rsBusy;
    logic             rtBusy;
    logic             hazard;
    logic             issue;
    logic             doSet;
    logic             stallAll;
    logic             flushAll;
    logic [CNT_W-1:0] setVal;

    function automatic logic [CNT_W-1:0] satDec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign rsBusy = id_uses_rs && (cnt[id_rs] != '0);
    assign rtBusy = id_uses_rt && (cnt[id_rt] != '0);
    assign hazard = id_valid && (rsBusy || rtBusy);
    assign issue  = id_valid && !hazard && !redirect;
    assign setVal = id_mem_read ? LOAD_CNT : ALU_CNT;
    // With forwarding only loads need tracking; ALU results are bypassed.
    assign doSet  = issue && id_reg_write && (id_rd != '0) && ((FORWARD_EN == 0) || id_mem_read);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cntNext[i] = satDec(cnt[i]);
            if (doSet && (id_rd == REG_ADDR_W'(i)) && (setVal > cntNext[i]))
                cntNext[i] = setVal;
        end
        cntNext[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= cntNext[i];
        end
    end

    // Outputs stay quiet while reset is held, even if redirect toggles.
    assign stallAll    = hazard && !redirect && reset;
    assign flushAll    = redirect && reset;
    assign stall_pc    = stallAll;
    assign stall_ifid  = stallAll;
    assign bubble_idex = stallAll;
    assign flush_ifid  = flushAll;
    assign flush_idex  = flushAll;
    assign flush_exmem = flushAll;

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallAll)
                stallCnt <= satInc(stallCnt);
            if (redirect)
                flushCnt <= satInc(flushCnt);
        end
    end

    assign stall_count = stallCnt;
    assign flush_count = flushCnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
